// File: rtl/mem_split_arbiter.sv
// Two-master round-robin arbiter onto one split-transaction slave port; read responses are
// steered back through an in-order master-id FIFO. Define MEM_SPLIT_ARB_FIXED_PRIO_EN for fixed m0 priority.
module mem_split_arbiter #(
    parameter int unsigned RESP_FIFO_DEPTH_POW = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_bi,
    input  logic [3:0]  m0_be_bi,
    input  logic [31:0] m0_wdata_bi,
    output logic        m0_ack_o,
    output logic        m0_resp_o,
    output logic [31:0] m0_rdata_bo,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_bi,
    input  logic [3:0]  m1_be_bi,
    input  logic [31:0] m1_wdata_bi,
    output logic        m1_ack_o,
    output logic        m1_resp_o,
    output logic [31:0] m1_rdata_bo,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_bo,
    output logic [3:0]  s_be_bo,
    output logic [31:0] s_wdata_bo,
    input  logic        s_ack_i,
    input  logic        s_resp_i,
    input  logic [31:0] s_rdata_bi,
    output logic        err_o
);

    localparam int unsigned Depth = 1 << RESP_FIFO_DEPTH_POW;
    localparam int unsigned PtrW  = RESP_FIFO_DEPTH_POW + 1;

    logic             lock_vld_q, lock_vld_d;
    logic             lock_id_q, lock_id_d;
    logic             rr_last_q, rr_last_d;
    logic             err_q, err_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  cnt_q, cnt_d;
    logic [Depth-1:0] id_mem_q, id_mem_d;

    logic                          gnt_vld, gnt_id;
    logic                          gnt_req, gnt_we;
    logic [31:0]                   gnt_addr, gnt_wdata;
    logic [3:0]                    gnt_be;
    logic                          rd_block, accept, push, pop, head_id;
    logic [RESP_FIFO_DEPTH_POW-1:0] wr_idx, rd_idx;

    assign wr_idx  = wr_ptr_q[RESP_FIFO_DEPTH_POW-1:0];
    assign rd_idx  = rd_ptr_q[RESP_FIFO_DEPTH_POW-1:0];
    assign head_id = id_mem_q[rd_idx];
    // Count never exceeds Depth, so its MSB alone marks "full".
    assign rd_block = cnt_q[PtrW-1];

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (lock_vld_q) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_id_q;
        end else if (m0_req_i && m1_req_i) begin
            gnt_vld = 1'b1;
`ifdef MEM_SPLIT_ARB_FIXED_PRIO_EN
            gnt_id  = 1'b0;
`else
            gnt_id  = ~rr_last_q;
`endif
        end else if (m0_req_i) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
        end else if (m1_req_i) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
        end
    end

    always_comb begin
        gnt_req   = 1'b0;
        gnt_we    = 1'b0;
        gnt_addr  = '0;
        gnt_be    = '0;
        gnt_wdata = '0;
        if (gnt_vld) begin
            if (gnt_id) begin
                gnt_req   = m1_req_i;
                gnt_we    = m1_we_i;
                gnt_addr  = m1_addr_bi;
                gnt_be    = m1_be_bi;
                gnt_wdata = m1_wdata_bi;
            end else begin
                gnt_req   = m0_req_i;
                gnt_we    = m0_we_i;
                gnt_addr  = m0_addr_bi;
                gnt_be    = m0_be_bi;
                gnt_wdata = m0_wdata_bi;
            end
        end
    end

    assign accept = s_req_o && s_ack_i;
    assign push   = accept && !gnt_we;
    assign pop    = s_resp_i && (cnt_q != '0);

    always_comb begin
        lock_vld_d = 1'b0;
        lock_id_d  = lock_id_q;
        rr_last_d  = rr_last_q;
        err_d      = err_q || (s_resp_i && (cnt_q == '0));
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        id_mem_d   = id_mem_q;
        if (accept) begin
            rr_last_d = gnt_id;
        end else if (gnt_req) begin
            // Hold the grant on a stalled (or read-blocked) master.
            lock_vld_d = 1'b1;
            lock_id_d  = gnt_id;
        end
        if (push) begin
            id_mem_d[wr_idx] = gnt_id;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            rr_last_q  <= 1'b1;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            id_mem_q   <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            rr_last_q  <= rr_last_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            id_mem_q   <= id_mem_d;
        end
    end

    always_comb begin
        s_req_o     = gnt_req && !(!gnt_we && rd_block);
        s_we_o      = gnt_we;
        s_addr_bo   = gnt_addr;
        s_be_bo     = gnt_be;
        s_wdata_bo  = gnt_wdata;
        m0_ack_o    = accept && !gnt_id;
        m1_ack_o    = accept && gnt_id;
        m0_resp_o   = pop && !head_id;
        m1_resp_o   = pop && head_id;
        m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
        m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;
        err_o       = err_q;
    end

endmodule

// File: tb/tb_mem_split_arbiter.sv
// Directed bench for mem_split_arbiter; a negedge monitor pops expected acks/responses from queues.
module tb_mem_split_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_bi, m0_wdata_bi, m1_addr_bi, m1_wdata_bi;
    logic [3:0]  m0_be_bi, m1_be_bi;
    logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
    logic [31:0] m0_rdata_bo, m1_rdata_bo;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_bo, s_wdata_bo;
    logic [3:0]  s_be_bo;
    logic        s_ack_i, s_resp_i;
    logic [31:0] s_rdata_bi;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    logic        exp_ack_id[$];
    logic [31:0] exp_ack_addr[$];
    logic        exp_resp_id[$];
    logic [31:0] exp_resp_data[$];

    mem_split_arbiter #(.RESP_FIFO_DEPTH_POW(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi), .m0_be_bi(m0_be_bi),
        .m0_wdata_bi(m0_wdata_bi), .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o),
        .m0_rdata_bo(m0_rdata_bo),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi), .m1_be_bi(m1_be_bi),
        .m1_wdata_bi(m1_wdata_bi), .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o),
        .m1_rdata_bo(m1_rdata_bo),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo), .s_be_bo(s_be_bo),
        .s_wdata_bo(s_wdata_bo), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i),
        .s_rdata_bi(s_rdata_bi), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every ack / response the DUT presents must match the head of its queue.
    always @(negedge clk_i) begin
        if (m0_ack_o || m1_ack_o) begin
            chk("ack_expected", 32'(exp_ack_id.size() != 0), 32'd1);
            chk("ack_onehot", 32'(m0_ack_o & m1_ack_o), 32'd0);
            if (exp_ack_id.size() != 0) begin
                chk("ack_id", 32'(m1_ack_o), 32'(exp_ack_id.pop_front()));
                chk("ack_addr", s_addr_bo, exp_ack_addr.pop_front());
            end
        end
        if (m0_resp_o || m1_resp_o) begin
            chk("resp_expected", 32'(exp_resp_id.size() != 0), 32'd1);
            chk("resp_onehot", 32'(m0_resp_o & m1_resp_o), 32'd0);
            if (exp_resp_id.size() != 0) begin
                chk("resp_id", 32'(m1_resp_o), 32'(exp_resp_id.pop_front()));
                chk("resp_data", m1_resp_o ? m1_rdata_bo : m0_rdata_bo, exp_resp_data.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic idle();
        m0_req_i = 0; m0_we_i = 0; m0_addr_bi = 0; m0_be_bi = 0; m0_wdata_bi = 0;
        m1_req_i = 0; m1_we_i = 0; m1_addr_bi = 0; m1_be_bi = 0; m1_wdata_bi = 0;
        s_ack_i = 0; s_resp_i = 0; s_rdata_bi = 0;
    endtask

    task automatic drive(input logic m, input logic req, input logic we, input logic [31:0] addr);
        if (m) begin
            m1_req_i = req; m1_we_i = we; m1_addr_bi = addr; m1_be_bi = 4'hF; m1_wdata_bi = ~addr;
        end else begin
            m0_req_i = req; m0_we_i = we; m0_addr_bi = addr; m0_be_bi = 4'hF; m0_wdata_bi = ~addr;
        end
    endtask

    task automatic exp_ack(input logic id, input logic [31:0] addr);
        exp_ack_id.push_back(id);
        exp_ack_addr.push_back(addr);
    endtask

    task automatic exp_resp(input logic id, input logic [31:0] data);
        exp_resp_id.push_back(id);
        exp_resp_data.push_back(data);
    endtask

    logic        order_rr[4];
    logic [31:0] resp_data[4];

    initial begin
        idle();
        rst_i = 1;
        sample();
        chk("rst_s_req", 32'(s_req_o), 0);
        chk("rst_acks", 32'({m0_ack_o, m1_ack_o}), 0);
        chk("rst_resps", 32'({m0_resp_o, m1_resp_o}), 0);
        chk("rst_s_addr", s_addr_bo, 0);
        chk("rst_rdata", m0_rdata_bo | m1_rdata_bo, 0);
        chk("rst_err", 32'(err_o), 0);
        step();
        rst_i = 0;

        // Contention: both write continuously.
`ifdef MEM_SPLIT_ARB_FIXED_PRIO_EN
        order_rr = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        order_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        drive(0, 1, 1, 32'h0000_0100);
        drive(1, 1, 1, 32'h0000_0200);
        s_ack_i = 1;
        for (int i = 0; i < 4; i++) begin
            exp_ack(order_rr[i], order_rr[i] ? 32'h0000_0200 : 32'h0000_0100);
            sample();
            step();
        end
        idle();
        step();

        // Single master read and response.
        drive(0, 1, 0, 32'h8000_0004);
        s_ack_i = 1;
        exp_ack(0, 32'h8000_0004);
        sample();
        step();
        idle();
        s_resp_i = 1;
        s_rdata_bi = 32'hA5A5_A5A5;
        exp_resp(0, 32'hA5A5_A5A5);
        sample();
        chk("single_m1_resp", 32'(m1_resp_o), 0);
        chk("single_m1_rdata", m1_rdata_bo, 0);
        step();
        idle();
        step();

        // Stall lock on m1 while m0 also requests.
        drive(1, 1, 1, 32'h0000_1110);
        sample();
        chk("lock_addr_c1", s_addr_bo, 32'h0000_1110);
        step();
        drive(0, 1, 1, 32'h0000_2220);
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("lock_addr_hold", s_addr_bo, 32'h0000_1110);
            step();
        end
        s_ack_i = 1;
        exp_ack(1, 32'h0000_1110);
        sample();
        step();
        drive(1, 0, 0, 0);
        exp_ack(0, 32'h0000_2220);
        sample();
        step();
        idle();
        step();

        // Fill the depth-4 FIFO, then a blocked read and an unblocked write.
        s_ack_i = 1;
        for (int i = 0; i < 4; i++) begin
            idle();
            s_ack_i = 1;
            drive(1'(i), 1, 0, 32'h10 + 32'(4 * i));
            exp_ack(1'(i), 32'h10 + 32'(4 * i));
            sample();
            step();
        end
        idle();
        s_ack_i = 1;
        drive(0, 1, 0, 32'h20);
        sample();
        chk("full_rd_block", 32'(s_req_o), 0);
        step();
        drive(0, 1, 1, 32'h24);
        exp_ack(0, 32'h24);
        sample();
        chk("full_wr_pass", 32'(s_req_o), 1);
        step();
        idle();
        resp_data = '{32'hD000_0000, 32'hD111_1111, 32'hD222_2222, 32'hD333_3333};
        for (int i = 0; i < 4; i++) begin
            s_resp_i = 1;
            s_rdata_bi = resp_data[i];
            exp_resp(1'(i), resp_data[i]);
            sample();
            step();
        end
        idle();
        sample();
        chk("full_err_clear", 32'(err_o), 0);
        step();

        // Spurious response.
        s_resp_i = 1;
        s_rdata_bi = 32'hDEAD_BEEF;
        sample();
        chk("spur_no_resp", 32'({m0_resp_o, m1_resp_o}), 0);
        step();
        idle();
        sample();
        chk("spur_err_set", 32'(err_o), 1);
        step();
        step();
        sample();
        chk("spur_err_sticky", 32'(err_o), 1);
        step();

        // Reset with two reads outstanding.
        s_ack_i = 1;
        drive(0, 1, 0, 32'h30);
        exp_ack(0, 32'h30);
        sample();
        step();
        drive(0, 0, 0, 0);
        drive(1, 1, 0, 32'h34);
        exp_ack(1, 32'h34);
        sample();
        step();
        idle();
        rst_i = 1;
        sample();
        chk("midrst_err", 32'(err_o), 0);
        chk("midrst_s_req", 32'(s_req_o), 0);
        step();
        rst_i = 0;
        sample();
        chk("postrst_err", 32'(err_o), 0);
        step();
        s_resp_i = 1;
        s_rdata_bi = 32'h1234_5678;
        sample();
        chk("stray_no_resp", 32'({m0_resp_o, m1_resp_o}), 0);
        step();
        idle();
        sample();
        chk("stray_err", 32'(err_o), 1);
        step();

        chk("ack_queue_drained", 32'(exp_ack_id.size()), 0);
        chk("resp_queue_drained", 32'(exp_resp_id.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
